truxton2_snd_wrq: RTL and testbench
===================================

// Module: truxton2_snd_wrq
// PURPOSE
// - Write queue between the 68K sound decode and the YM2151/OKI sound block.
// - Buffers CPU writes to the YM2151 (address/data) and the OKI M6295 in a FIFO.
// - Replays each write to the chips aligned to their clock enables.
// - Honours the YM2151 busy flag, so the 68K never stalls on a slow FM chip.
// - Sits downstream of truxton2_cpu and upstream of truxton2_sound.
// PARAMETERS
// DEPTH      8    FIFO entries; power of two, 2..64
// MIN_BUSY   2    YM_CEN pulses to wait after a YM data write before polling busy
// TIMEOUT    128  YM_CEN pulses of busy polling before giving up; must be > MIN_BUSY
// PORTS
// CLK            in   1  system clock (48 MHz)
// RESET_N        in   1  asynchronous, active-low reset
// WR_STB         in   1  one-cycle CPU write strobe
// WR_TGT         in   2  target: 0 YM address, 1 YM data, 2 OKI, 3 ignored (no push)
// WR_DATA        in   8  write byte
// FULL           out  1  FIFO holds DEPTH entries
// EMPTY          out  1  FIFO holds 0 entries and FSM is IDLE
// OVF            out  1  sticky: a push was dropped
// TMO            out  1  sticky: busy poll timed out
// YM_CEN         in   1  YM2151 clock enable (3.375 MHz)
// OKI_CEN        in   1  OKI clock enable (4 MHz)
// YM2151_DOUT    in   8  YM2151 status; bit7 = busy
// YM2151_CS      out  1  chip select to the YM2151
// YM2151_WE      out  1  write enable to the YM2151
// YM2151_WR_CMD  out  1  1 = address write, 0 = data write
// YM2151_DIN     out  8  byte to the YM2151
// OKI_CS         out  1  chip select to the OKI
// OKI_WE         out  1  write enable to the OKI
// OKI_DIN        out  8  byte to the OKI
// BEHAVIOUR
// - Reset state, async on RESET_N low:
//   - FIFO pointers and count 0, FSM in IDLE.
//   - All CS/WE low; DIN 0; YM2151_WR_CMD 0.
//   - OVF, TMO 0; FULL 0, EMPTY 1.
// - FIFO entry: {tgt[1:0], data[7:0]}.
// - Push rules:
//   - Push happens on WR_STB with WR_TGT != 3.
//   - A push is accepted when count < DEPTH, or when a pop happens in the same cycle.
//   - Otherwise the push is dropped and OVF is set (it stays set until reset).
//   - Simultaneous push and pop: count is unchanged and the order is kept.
//   - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
// - FSM states: IDLE, ISSUE, SETTLE, POLL.
//   - IDLE: if count > 0, pop the head entry into the output regs and go to ISSUE.
//     The entry's target chip gets CS=WE=1; YM2151_WR_CMD = (tgt==0).
//   - ISSUE: hold CS/WE/DIN until the target's CEN is high in a cycle.
//     That cycle is the capture cycle; on the next cycle CS/WE drop to 0.
//     - YM address write -> IDLE.
//     - OKI write -> IDLE.
//     - YM data write -> SETTLE, wait counter cleared.
//   - SETTLE: count YM_CEN pulses; after MIN_BUSY pulses go to POLL.
//   - POLL: on each YM_CEN, sample YM2151_DOUT[7].
//     - If 0, go to IDLE.
//     - If the wait counter reaches TIMEOUT, set TMO and go to IDLE.
// - Latency: push at cycle t into an empty, idle queue -> CS/WE high at t+2.
// - Back-to-back entries: at least one CS-low cycle between any two writes.
// - Outputs are registered; DIN stays stable for the whole CS/WE window.
// - EMPTY = (count==0) && IDLE, so the CPU can poll for drain.
// - Mid-operation RESET_N drops the in-flight write and all queued writes at once.
// TESTING
// - YM addr 0x08 then data 0x78, FIFO empty, busy=0:
//   - CS/WE up at t+2 with WR_CMD=1, DIN=0x08, held to first YM_CEN.
//   - Then the data write with WR_CMD=0, DIN=0x78.
// - Busy held high 10 YM_CEN after a data write, next entry queued:
//   - Next write issues only after busy=0 is sampled in POLL, never inside SETTLE.
// - Push DEPTH+1 entries with the chip stalled (busy=1):
//   - FULL at DEPTH entries; the extra push is dropped; OVF=1.
//   - Only the first DEPTH bytes are replayed, in order.
// - Busy stuck at 1:
//   - After MIN_BUSY+TIMEOUT YM_CEN pulses TMO=1.
//   - The queue resumes with the next entry.
// - OKI write 0x80 queued behind a YM data write:
//   - OKI_CS/WE rise only after the YM poll completes; held to the first OKI_CEN.
// - RESET_N pulsed low while in ISSUE with 3 entries queued:
//   - CS/WE drop to 0 immediately (async); EMPTY=1.
//   - No further writes after release.

Source files
------------

// File: rtl/truxton2_snd_wrq.sv
// ---------------------------------------------------------------------------
// truxton2_snd_wrq
//
// Write queue between the 68K sound decode and the YM2151 / OKI M6295 block.
// The CPU writes are buffered in a small FIFO. They are then replayed one at
// a time to the target chip, aligned to that chip's clock enable. After every
// YM2151 data write the queue waits out the FM chip's busy period, so the 68K
// never has to stall on the slow chip.
//
// Ports
//   clk            system clock (48 MHz)
//   reset_n        asynchronous active-low reset
//   wr_stb         one-cycle CPU write strobe
//   wr_tgt         0 YM address, 1 YM data, 2 OKI, 3 ignored (no push)
//   wr_data        write byte
//   full           FIFO holds DEPTH entries
//   empty          FIFO holds no entries and no write is in flight
//   ovf            sticky: a push was dropped because the FIFO was full
//   tmo            sticky: a YM busy poll gave up
//   ym_cen         YM2151 clock enable
//   oki_cen        OKI clock enable
//   ym2151_dout    YM2151 status byte, bit 7 = busy
//   ym2151_cs/we   YM2151 chip select / write enable
//   ym2151_wr_cmd  1 = address write, 0 = data write
//   ym2151_din     byte to the YM2151
//   oki_cs/we      OKI chip select / write enable
//   oki_din        byte to the OKI
// ---------------------------------------------------------------------------
module truxton2_snd_wrq #(
    parameter int DEPTH    = 8,
    parameter int MIN_BUSY = 2,
    parameter int TIMEOUT  = 128
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_stb,
    input  logic [1:0] wr_tgt,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic       tmo,
    input  logic       ym_cen,
    input  logic       oki_cen,
    input  logic [7:0] ym2151_dout,
    output logic       ym2151_cs,
    output logic       ym2151_we,
    output logic       ym2151_wr_cmd,
    output logic [7:0] ym2151_din,
    output logic       oki_cs,
    output logic       oki_we,
    output logic [7:0] oki_din
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [WW-1:0] SETTLE_LAST = WW'(MIN_BUSY - 1);
    localparam logic [WW-1:0] POLL_LAST   = WW'(TIMEOUT - 1);

    localparam logic [1:0] TGT_YM_ADDR = 2'd0;
    localparam logic [1:0] TGT_YM_DATA = 2'd1;
    localparam logic [1:0] TGT_OKI     = 2'd2;
    localparam logic [1:0] TGT_NONE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_POLL
    } state_t;

    // FIFO storage: {tgt[1:0], data[7:0]} per entry
    logic [9:0]    fifo_mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    state_t        state_reg;
    logic [1:0]    tgt_reg;
    logic [WW-1:0] wait_cnt_reg;

    logic          ym_cs_reg;
    logic          ym_we_reg;
    logic          ym_wr_cmd_reg;
    logic [7:0]    ym_din_reg;
    logic          oki_cs_reg;
    logic          oki_we_reg;
    logic [7:0]    oki_din_reg;
    logic          ovf_reg;
    logic          tmo_reg;

    logic          push_req;
    logic          pop;
    logic          push_ok;
    logic          fifo_full;
    logic [9:0]    head;
    logic          cen_hit;
    logic          unused_dout;

    assign fifo_full = (count_reg == DEPTH_C);
    assign push_req  = wr_stb && (wr_tgt != TGT_NONE);
    // The FSM only pops from IDLE, so a pop never needs a busy check here.
    assign pop       = (state_reg == S_IDLE) && (count_reg != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign head      = fifo_mem[rd_ptr_reg];
    // Capture happens on the clock enable of whichever chip the write targets.
    assign cen_hit   = (tgt_reg == TGT_OKI) ? oki_cen : ym_cen;

    assign unused_dout = ^ym2151_dout[6:0];

    // Storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= {wr_tgt, wr_data};
        end
    end

    // Pointers, occupancy and overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_req && !push_ok) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Replay FSM with registered chip-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            tgt_reg       <= TGT_YM_ADDR;
            wait_cnt_reg  <= '0;
            ym_cs_reg     <= 1'b0;
            ym_we_reg     <= 1'b0;
            ym_wr_cmd_reg <= 1'b0;
            ym_din_reg    <= 8'h00;
            oki_cs_reg    <= 1'b0;
            oki_we_reg    <= 1'b0;
            oki_din_reg   <= 8'h00;
            tmo_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pop) begin
                        tgt_reg <= head[9:8];
                        if (head[9:8] == TGT_OKI) begin
                            oki_cs_reg  <= 1'b1;
                            oki_we_reg  <= 1'b1;
                            oki_din_reg <= head[7:0];
                        end else begin
                            ym_cs_reg     <= 1'b1;
                            ym_we_reg     <= 1'b1;
                            ym_wr_cmd_reg <= (head[9:8] == TGT_YM_ADDR);
                            ym_din_reg    <= head[7:0];
                        end
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The chip latches the byte in the cycle its enable is
                    // high; strobes drop right after. DIN is left as is.
                    if (cen_hit) begin
                        ym_cs_reg  <= 1'b0;
                        ym_we_reg  <= 1'b0;
                        oki_cs_reg <= 1'b0;
                        oki_we_reg <= 1'b0;
                        if (tgt_reg == TGT_YM_DATA) begin
                            wait_cnt_reg <= '0;
                            state_reg    <= S_SETTLE;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
                S_SETTLE: begin
                    // The busy flag is not valid for a few FM clocks after
                    // a data write, so do not look at it yet.
                    if (ym_cen) begin
                        if (wait_cnt_reg == SETTLE_LAST) begin
                            wait_cnt_reg <= '0;
                            state_reg    <= S_POLL;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + WW'(1);
                        end
                    end
                end
                S_POLL: begin
                    if (ym_cen) begin
                        if (!ym2151_dout[7]) begin
                            state_reg <= S_IDLE;
                        end else if (wait_cnt_reg == POLL_LAST) begin
                            tmo_reg   <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + WW'(1);
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign full          = fifo_full;
    assign empty         = (count_reg == '0) && (state_reg == S_IDLE);
    assign ovf           = ovf_reg;
    assign tmo           = tmo_reg;
    assign ym2151_cs     = ym_cs_reg;
    assign ym2151_we     = ym_we_reg;
    assign ym2151_wr_cmd = ym_wr_cmd_reg;
    assign ym2151_din    = ym_din_reg;
    assign oki_cs        = oki_cs_reg;
    assign oki_we        = oki_we_reg;
    assign oki_din       = oki_din_reg;

endmodule

// File: tb/tb_truxton2_snd_wrq.sv
// ---------------------------------------------------------------------------
// tb_truxton2_snd_wrq
//
// Directed bench for the sound write queue. Clock enables are driven by hand,
// so every capture point is known exactly. A monitor logs every write a chip
// would latch ({is_oki, wr_cmd, din}). It also counts any case where a strobe
// is still high in the cycle right after a capture.
// ---------------------------------------------------------------------------
module tb_truxton2_snd_wrq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_stb;
    logic [1:0] wr_tgt;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       tmo;
    logic       ym_cen;
    logic       oki_cen;
    logic [7:0] ym2151_dout;
    logic       ym2151_cs;
    logic       ym2151_we;
    logic       ym2151_wr_cmd;
    logic [7:0] ym2151_din;
    logic       oki_cs;
    logic       oki_we;
    logic [7:0] oki_din;

    int         n_checks = 0;
    int         n_errs   = 0;
    int         gap_err  = 0;
    logic       prev_cap = 1'b0;
    logic [9:0] cap_q [$];
    int         base;

    always #5 clk = ~clk;

    truxton2_snd_wrq #(
        .DEPTH    (8),
        .MIN_BUSY (2),
        .TIMEOUT  (128)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_stb        (wr_stb),
        .wr_tgt        (wr_tgt),
        .wr_data       (wr_data),
        .full          (full),
        .empty         (empty),
        .ovf           (ovf),
        .tmo           (tmo),
        .ym_cen        (ym_cen),
        .oki_cen       (oki_cen),
        .ym2151_dout   (ym2151_dout),
        .ym2151_cs     (ym2151_cs),
        .ym2151_we     (ym2151_we),
        .ym2151_wr_cmd (ym2151_wr_cmd),
        .ym2151_din    (ym2151_din),
        .oki_cs        (oki_cs),
        .oki_we        (oki_we),
        .oki_din       (oki_din)
    );

    // Capture log: a chip latches when its CS/WE and its enable are all high.
    always @(posedge clk) begin
        logic c;
        c = 1'b0;
        if (ym2151_cs && ym2151_we && ym_cen) begin
            cap_q.push_back({1'b0, ym2151_wr_cmd, ym2151_din});
            $display("ym write  cmd=%0b din=%02h", ym2151_wr_cmd, ym2151_din);
            c = 1'b1;
        end
        if (oki_cs && oki_we && oki_cen) begin
            cap_q.push_back({1'b1, 1'b0, oki_din});
            $display("oki write din=%02h", oki_din);
            c = 1'b1;
        end
        if (prev_cap && (ym2151_cs || oki_cs)) begin
            gap_err++;
        end
        prev_cap = c;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [7:0] d);
        wr_stb  = 1'b1;
        wr_tgt  = t;
        wr_data = d;
        $display("push tgt=%0d data=%02h", t, d);
        tick();
        wr_stb  = 1'b0;
        wr_tgt  = 2'd0;
        wr_data = 8'h00;
    endtask

    task automatic pulse_ym();
        ym_cen = 1'b1;
        tick();
        ym_cen = 1'b0;
        tick();
    endtask

    function automatic logic [9:0] cap_at(input int idx);
        if (idx >= 0 && idx < cap_q.size()) return cap_q[idx];
        return 10'h3FF;
    endfunction

    initial begin
        reset_n     = 1'b0;
        wr_stb      = 1'b0;
        wr_tgt      = 2'd0;
        wr_data     = 8'h00;
        ym_cen      = 1'b0;
        oki_cen     = 1'b0;
        ym2151_dout = 8'h00;
        tick();
        tick();

        // ---- reset state ----
        check("rst_ym_cs",  ym2151_cs,     0);
        check("rst_ym_we",  ym2151_we,     0);
        check("rst_wr_cmd", ym2151_wr_cmd, 0);
        check("rst_ym_din", ym2151_din,    0);
        check("rst_oki_cs", oki_cs,        0);
        check("rst_oki_we", oki_we,        0);
        check("rst_oki_din", oki_din,      0);
        check("rst_full",   full,          0);
        check("rst_empty",  empty,         1);
        check("rst_ovf",    ovf,           0);
        check("rst_tmo",    tmo,           0);
        reset_n = 1'b1;
        tick();

        // ---- YM address 0x08 then data 0x78 ----
        push(2'd0, 8'h08);
        check("lat_t1_cs", ym2151_cs, 0);
        tick();
        check("lat_t2_cs",  ym2151_cs,     1);
        check("lat_t2_we",  ym2151_we,     1);
        check("lat_t2_cmd", ym2151_wr_cmd, 1);
        check("lat_t2_din", ym2151_din,    8'h08);
        check("busy_empty", empty,         0);
        push(2'd1, 8'h78);
        check("addr_hold_cs", ym2151_cs, 1);
        ym_cen = 1'b1;
        check("addr_capture_cs", ym2151_cs, 1);
        tick();
        ym_cen = 1'b0;
        check("addr_gap_cs", ym2151_cs, 0);
        tick();
        check("data_cs",  ym2151_cs,     1);
        check("data_cmd", ym2151_wr_cmd, 0);
        check("data_din", ym2151_din,    8'h78);
        pulse_ym();
        check("data_drop_cs", ym2151_cs, 0);
        pulse_ym();
        pulse_ym();
        check("poll_not_empty", empty, 0);
        pulse_ym();
        check("t1_empty", empty, 1);
        check("t1_ncap", cap_q.size(), 2);
        check("t1_cap0", cap_at(0), 10'h108);
        check("t1_cap1", cap_at(1), 10'h078);

        // ---- busy held for 10 YM_CEN, next entry queued ----
        ym2151_dout = 8'h80;
        push(2'd1, 8'h11);
        push(2'd0, 8'h22);           // lands in the same cycle as the pop
        check("t2_cs",  ym2151_cs,  1);
        check("t2_din", ym2151_din, 8'h11);
        base = cap_q.size();
        pulse_ym();
        repeat (10) pulse_ym();
        check("t2_no_issue_ncap", cap_q.size(), base + 1);
        check("t2_no_issue_cs",   ym2151_cs,    0);
        ym2151_dout = 8'h00;
        pulse_ym();
        check("t2_next_cs",  ym2151_cs,     1);
        check("t2_next_cmd", ym2151_wr_cmd, 1);
        check("t2_next_din", ym2151_din,    8'h22);
        pulse_ym();
        check("t2_empty", empty, 1);
        check("t2_tmo",   tmo,   0);
        check("t2_cap",   cap_at(base + 1), 10'h122);

        // ---- overflow: stall in SETTLE, push DEPTH+1 entries ----
        ym2151_dout = 8'h80;
        push(2'd1, 8'hA0);
        tick();
        base = cap_q.size();
        pulse_ym();                  // A0 captured, FSM now stalled in SETTLE
        for (int i = 0; i < 7; i++) push(2'd1, 8'hB0 + 8'(i));
        check("t3_full_at7", full, 0);
        push(2'd1, 8'hB7);
        check("t3_full_at8", full, 1);
        check("t3_ovf_pre",  ovf,  0);
        push(2'd1, 8'hB8);
        check("t3_ovf",      ovf,  1);
        check("t3_full_kept", full, 1);
        ym2151_dout = 8'h00;
        for (int i = 0; i < 100 && !empty; i++) pulse_ym();
        check("t3_drained", empty, 1);
        check("t3_full_off", full, 0);
        check("t3_ovf_sticky", ovf, 1);
        check("t3_ncap", cap_q.size(), base + 9);
        check("t3_cap_a0", cap_at(base), 10'h0A0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_cap_b%0d", i), cap_at(base + 1 + i), 10'h0B0 + 10'(i));
        end

        // ---- busy stuck: timeout after MIN_BUSY+TIMEOUT pulses ----
        ym2151_dout = 8'h80;
        push(2'd1, 8'hC0);
        push(2'd0, 8'hC1);
        check("t4_cs",  ym2151_cs,  1);
        check("t4_din", ym2151_din, 8'hC0);
        pulse_ym();                  // capture
        repeat (129) pulse_ym();
        check("t4_tmo_early", tmo,       0);
        check("t4_held_cs",   ym2151_cs, 0);
        pulse_ym();
        check("t4_tmo",       tmo,           1);
        check("t4_resume_cs", ym2151_cs,     1);
        check("t4_resume_cmd", ym2151_wr_cmd, 1);
        check("t4_resume_din", ym2151_din,   8'hC1);
        pulse_ym();
        check("t4_empty", empty, 1);

        // ---- OKI write queued behind a YM data write ----
        push(2'd1, 8'hD0);
        push(2'd2, 8'h80);
        check("t5_ym_cs", ym2151_cs, 1);
        pulse_ym();
        pulse_ym();
        pulse_ym();
        check("t5_oki_wait_settle", oki_cs, 0);
        pulse_ym();                  // busy still high in POLL
        check("t5_oki_wait_poll", oki_cs, 0);
        ym2151_dout = 8'h00;
        pulse_ym();
        check("t5_oki_cs",  oki_cs,    1);
        check("t5_oki_we",  oki_we,    1);
        check("t5_oki_din", oki_din,   8'h80);
        check("t5_ym_idle", ym2151_cs, 0);
        base = cap_q.size();
        pulse_ym();
        check("t5_oki_ignores_ym", oki_cs, 1);
        oki_cen = 1'b1;
        tick();
        oki_cen = 1'b0;
        check("t5_oki_drop", oki_cs, 0);
        check("t5_oki_cap",  cap_at(base), 10'h280);
        tick();
        check("t5_empty", empty, 1);

        // ---- reset in ISSUE with 3 entries queued ----
        push(2'd0, 8'hE0);
        push(2'd0, 8'hE1);
        push(2'd0, 8'hE2);
        push(2'd0, 8'hE3);
        check("t6_issue_cs",  ym2151_cs,  1);
        check("t6_issue_din", ym2151_din, 8'hE0);
        reset_n = 1'b0;
        #1;
        check("t6_async_cs",  ym2151_cs, 0);
        check("t6_async_we",  ym2151_we, 0);
        check("t6_empty",     empty,     1);
        check("t6_ovf_clr",   ovf,       0);
        check("t6_tmo_clr",   tmo,       0);
        tick();
        tick();
        reset_n = 1'b1;
        base = cap_q.size();
        repeat (10) pulse_ym();
        oki_cen = 1'b1;
        tick();
        oki_cen = 1'b0;
        check("t6_no_writes", cap_q.size(), base);
        check("t6_cs_low",    ym2151_cs,    0);
        check("t6_empty_after", empty,      1);

        check("gap_between_writes", gap_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
